// File: rtl/cpu_sequencer.sv
// ---------------------------------------------------------------------------
// cpu_sequencer
//
// Multi-cycle instruction sequencer. It fetches a 16-bit instruction from an
// external instruction memory, holds it in an instruction register for the
// control unit and datapath, updates the program counter (sequential or jump),
// produces a one-cycle register-write strobe, and counts retired instructions.
// A fetch that never gets an ack drops the sequencer into a sticky FAULT state.
// The instruction 16'hFFFF halts it. Both end states are left only by reset.
//
// Ports
//   clk             in   single clock, rising edge
//   reset           in   synchronous, active-high
//   run             in   1 = execute, 0 = stop at the next instruction boundary
//   imem_req        out  fetch request (high only in FETCH)
//   imem_addr       out  fetch address (= pc)
//   imem_ack        in   imem_data valid this cycle
//   imem_data       in   instruction word
//   command_group   out  instruction register [15:13]
//   command         out  instruction register [12:10]
//   operand         out  instruction register [9:0]
//   write_enable_in in   register-write request from the control unit
//   branch_select   in   jump-candidate flag from the control unit
//   alu_cond        in   ALU branch condition
//   reg_write       out  one-cycle register-file write strobe (WRITEBACK)
//   pc              out  program counter
//   state           out  FSM state encoding
//   halted          out  high in HALT
//   fault           out  high in FAULT (fetch timeout)
//   retired         out  completed-instruction count, wraps at 16 bits
// ---------------------------------------------------------------------------
module cpu_sequencer #(
    parameter int PC_WIDTH      = 8,
    parameter int FETCH_TIMEOUT = 15
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                run,
    output logic                imem_req,
    output logic [PC_WIDTH-1:0] imem_addr,
    input  logic                imem_ack,
    input  logic [15:0]         imem_data,
    output logic [2:0]          command_group,
    output logic [2:0]          command,
    output logic [9:0]          operand,
    input  logic                write_enable_in,
    input  logic                branch_select,
    input  logic                alu_cond,
    output logic                reg_write,
    output logic [PC_WIDTH-1:0] pc,
    output logic [2:0]          state,
    output logic                halted,
    output logic                fault,
    output logic [15:0]         retired
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FETCH     = 3'd1,
        S_DECODE    = 3'd2,
        S_EXECUTE   = 3'd3,
        S_WRITEBACK = 3'd4,
        S_HALT      = 3'd5,
        S_FAULT     = 3'd6
    } state_t;

    // The wait counter only has to reach FETCH_TIMEOUT-1 before the fault fires.
    localparam int WAIT_W = (FETCH_TIMEOUT < 2) ? 1 : $clog2(FETCH_TIMEOUT);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(FETCH_TIMEOUT - 1);

    state_t              state_q,     state_d;
    logic [PC_WIDTH-1:0] pc_q,        pc_d;
    logic [15:0]         ir_q,        ir_d;
    logic [WAIT_W-1:0]   wait_q,      wait_d;
    logic [15:0]         retired_q,   retired_d;
    logic                imem_req_q,  imem_req_d;
    logic                reg_write_q, reg_write_d;
    logic                halted_q,    halted_d;
    logic                fault_q,     fault_d;

    logic [PC_WIDTH-1:0] jump_target;

    // Jump target is the low operand bits, zero-extended if PC_WIDTH > 10.
    assign jump_target = PC_WIDTH'(ir_q[9:0]);

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        wait_d    = '0;      // counter clears whenever FETCH is not the current state
        retired_d = retired_q;

        case (state_q)
            S_IDLE: begin
                if (run) state_d = S_FETCH;
            end
            S_FETCH: begin
                // An ack in the same cycle as the last allowed wait still wins.
                if (imem_ack) begin
                    ir_d    = imem_data;
                    state_d = S_DECODE;
                end else if (wait_q == WAIT_LAST) begin
                    state_d = S_FAULT;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            S_DECODE: begin
                state_d = (ir_q == 16'hFFFF) ? S_HALT : S_EXECUTE;
            end
            S_EXECUTE: begin
                pc_d = (branch_select && alu_cond) ? jump_target : pc_q + PC_WIDTH'(1);
                if (write_enable_in) begin
                    state_d = S_WRITEBACK;
                end else begin
                    // Non-writing instruction retires here; writing ones retire in WRITEBACK.
                    retired_d = retired_q + 16'd1;
                    state_d   = run ? S_FETCH : S_IDLE;
                end
            end
            S_WRITEBACK: begin
                retired_d = retired_q + 16'd1;
                state_d   = run ? S_FETCH : S_IDLE;
            end
            S_HALT:  state_d = S_HALT;
            S_FAULT: state_d = S_FAULT;
            default: state_d = S_IDLE;   // unused encoding 7 recovers to IDLE
        endcase

        // Status outputs are registered from the next state so they line up
        // exactly with the state they describe.
        imem_req_d  = (state_d == S_FETCH);
        reg_write_d = (state_d == S_WRITEBACK);
        halted_d    = (state_d == S_HALT);
        fault_d     = (state_d == S_FAULT);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            pc_q        <= '0;
            ir_q        <= '0;
            wait_q      <= '0;
            retired_q   <= '0;
            imem_req_q  <= 1'b0;
            reg_write_q <= 1'b0;
            halted_q    <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            ir_q        <= ir_d;
            wait_q      <= wait_d;
            retired_q   <= retired_d;
            imem_req_q  <= imem_req_d;
            reg_write_q <= reg_write_d;
            halted_q    <= halted_d;
            fault_q     <= fault_d;
        end
    end

    assign imem_req      = imem_req_q;
    assign imem_addr     = pc_q;
    assign command_group = ir_q[15:13];
    assign command       = ir_q[12:10];
    assign operand       = ir_q[9:0];
    assign reg_write     = reg_write_q;
    assign pc            = pc_q;
    assign state         = state_q;
    assign halted        = halted_q;
    assign fault         = fault_q;
    assign retired       = retired_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
module tb_cpu_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        run;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic        imem_ack;
    logic [15:0] imem_data;
    logic [2:0]  command_group;
    logic [2:0]  command;
    logic [9:0]  operand;
    logic        write_enable_in;
    logic        branch_select;
    logic        alu_cond;
    logic        reg_write;
    logic [7:0]  pc;
    logic [2:0]  state;
    logic        halted;
    logic        fault;
    logic [15:0] retired;

    int n_checks = 0;
    int n_pass   = 0;

    // Instruction-level reference: where the program counter should be and
    // how many instructions should have completed.
    logic [7:0]  m_pc;
    logic [15:0] m_ret;

    always #5 clk = ~clk;

    cpu_sequencer #(.PC_WIDTH(8), .FETCH_TIMEOUT(15)) dut (
        .clk(clk), .reset(reset), .run(run),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_data(imem_data),
        .command_group(command_group), .command(command), .operand(operand),
        .write_enable_in(write_enable_in), .branch_select(branch_select),
        .alu_cond(alu_cond), .reg_write(reg_write), .pc(pc), .state(state),
        .halted(halted), .fault(fault), .retired(retired)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got no finish want finish");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; run = 1'b0; imem_ack = 1'b0; imem_data = 16'($urandom);
        write_enable_in = 1'b0; branch_select = 1'b0; alu_cond = 1'b0;
        step(); step();
        reset = 1'b0;
        m_pc = 8'd0; m_ret = 16'd0;
    endtask

    task automatic start_run();
        run = 1'b1;
        step();
        n_checks++;
        if (state !== 3'd1 || imem_req !== 1'b1)
            $display("FAIL start_fetch: got state=%0d req=%b want state=1 req=1", state, imem_req);
        else n_pass++;
    endtask

    // Executes one non-halting instruction starting from FETCH.
    task automatic exec_instr(input logic [15:0] data, input int delay,
                              input bit we, input bit bs, input bit ac, input bit run_after);
        n_checks++;
        if (imem_req !== 1'b1 || imem_addr !== m_pc)
            $display("FAIL fetch_addr: got req=%b addr=%0h want req=1 addr=%0h", imem_req, imem_addr, m_pc);
        else n_pass++;
        for (int i = 0; i < delay; i++) begin
            run = 1'($urandom); imem_ack = 1'b0; imem_data = 16'($urandom);
            step();
        end
        n_checks++;
        if (state !== 3'd1)
            $display("FAIL fetch_wait: got state=%0d want 1 after %0d wait cycles", state, delay);
        else n_pass++;
        imem_data = data; imem_ack = 1'b1;
        step();
        // Acks and data outside FETCH must be ignored.
        imem_ack = 1'($urandom); imem_data = 16'($urandom);
        n_checks++;
        if (state !== 3'd2 || {command_group, command, operand} !== data || imem_req !== 1'b0 || reg_write !== 1'b0)
            $display("FAIL decode: got state=%0d ir=%h req=%b rw=%b want state=2 ir=%h req=0 rw=0",
                     state, {command_group, command, operand}, imem_req, reg_write, data);
        else n_pass++;
        write_enable_in = we; branch_select = bs; alu_cond = ac;
        run = we ? 1'($urandom) : run_after;
        step();
        n_checks++;
        if (state !== 3'd3 || pc !== m_pc || reg_write !== 1'b0 || {command_group, command, operand} !== data)
            $display("FAIL execute: got state=%0d pc=%0h rw=%b ir=%h want state=3 pc=%0h rw=0 ir=%h",
                     state, pc, reg_write, {command_group, command, operand}, m_pc, data);
        else n_pass++;
        step();
        m_pc = (bs && ac) ? data[7:0] : m_pc + 8'd1;
        if (we) begin
            run = run_after;
            write_enable_in = 1'($urandom); branch_select = 1'($urandom); alu_cond = 1'($urandom);
            n_checks++;
            if (state !== 3'd4 || reg_write !== 1'b1 || pc !== m_pc || retired !== m_ret)
                $display("FAIL writeback: got state=%0d rw=%b pc=%0h ret=%0d want state=4 rw=1 pc=%0h ret=%0d",
                         state, reg_write, pc, retired, m_pc, m_ret);
            else n_pass++;
            step();
        end
        m_ret = m_ret + 16'd1;
        imem_ack = 1'b0;
        n_checks++;
        if (state !== (run_after ? 3'd1 : 3'd0) || reg_write !== 1'b0 || pc !== m_pc || retired !== m_ret)
            $display("FAIL retire: got state=%0d rw=%b pc=%0h ret=%0d want state=%0d rw=0 pc=%0h ret=%0d",
                     state, reg_write, pc, retired, run_after ? 1 : 0, m_pc, m_ret);
        else n_pass++;
    endtask

    task automatic test_reset();
        imem_data = 16'h1234;
        do_reset();
        n_checks++;
        if (state !== 3'd0 || pc !== 8'd0 || retired !== 16'd0 || imem_req !== 1'b0 || reg_write !== 1'b0 ||
            halted !== 1'b0 || fault !== 1'b0 || {command_group, command, operand} !== 16'd0)
            $display("FAIL reset_state: got st=%0d pc=%0h ret=%0d req=%b rw=%b h=%b f=%b ir=%h want all zero",
                     state, pc, retired, imem_req, reg_write, halted, fault, {command_group, command, operand});
        else n_pass++;
        step(); step();
        n_checks++;
        if (state !== 3'd0 || imem_req !== 1'b0)
            $display("FAIL idle_hold: got state=%0d req=%b want state=0 req=0", state, imem_req);
        else n_pass++;
    endtask

    task automatic test_straight_line();
        do_reset();
        start_run();
        exec_instr(16'h2C05, 0, 1'b0, 1'b0, 1'b0, 1'b1);
        exec_instr(16'h4811, 0, 1'b1, 1'b0, 1'b0, 1'b1);
        n_checks++;
        if (pc !== 8'd2 || retired !== 16'd2)
            $display("FAIL straight_line: got pc=%0h ret=%0d want pc=2 ret=2", pc, retired);
        else n_pass++;
    endtask

    task automatic test_jump();
        exec_instr(16'h0003, 0, 1'b0, 1'b1, 1'b1, 1'b1);          // pc 2 -> 3
        exec_instr(16'hA02A, 1, 1'b0, 1'b1, 1'b1, 1'b1);          // taken -> 0x2A
        n_checks++;
        if (pc !== 8'h2A)
            $display("FAIL jump_taken: got pc=%0h want 2a", pc);
        else n_pass++;
        exec_instr(16'h0003, 0, 1'b1, 1'b1, 1'b1, 1'b1);          // back to 3
        exec_instr(16'hA02A, 0, 1'b0, 1'b1, 1'b0, 1'b1);          // not taken -> 4
        n_checks++;
        if (pc !== 8'h04)
            $display("FAIL jump_not_taken: got pc=%0h want 4", pc);
        else n_pass++;
        exec_instr(16'h0004, 0, 1'b0, 1'b1, 1'b1, 1'b1);          // self jump
        exec_instr(16'h0004, 2, 1'b0, 1'b1, 1'b1, 1'b1);
        n_checks++;
        if (imem_addr !== 8'h04)
            $display("FAIL self_jump: got addr=%0h want 4", imem_addr);
        else n_pass++;
    endtask

    task automatic test_wrap();
        exec_instr(16'h03FF, 0, 1'b0, 1'b1, 1'b1, 1'b1);          // jump to 0xFF
        exec_instr(16'h1234, 0, 1'b0, 1'b0, 1'b1, 1'b1);          // sequential from 0xFF
        n_checks++;
        if (imem_addr !== 8'h00)
            $display("FAIL pc_wrap: got addr=%0h want 0", imem_addr);
        else n_pass++;
    endtask

    task automatic test_random();
        logic [15:0] d;
        bit ra;
        for (int k = 0; k < 40; k++) begin
            d = 16'($urandom);
            if (d == 16'hFFFF) d = 16'h0000;
            ra = ($urandom_range(0, 3) != 0);
            exec_instr(d, $urandom_range(0, 3), 1'($urandom), 1'($urandom), 1'($urandom), ra);
            if (!ra) begin
                for (int j = 0; j < int'($urandom_range(1, 3)); j++) begin
                    imem_ack = 1'($urandom);
                    step();
                end
                imem_ack = 1'b0;
                n_checks++;
                if (state !== 3'd0 || pc !== m_pc || retired !== m_ret)
                    $display("FAIL stopped_idle: got state=%0d pc=%0h ret=%0d want state=0 pc=%0h ret=%0d",
                             state, pc, retired, m_pc, m_ret);
                else n_pass++;
                start_run();
            end
        end
    endtask

    task automatic test_halt();
        logic [7:0]  pc_at;
        logic [15:0] ret_at;
        pc_at = m_pc; ret_at = m_ret;
        imem_data = 16'hFFFF; imem_ack = 1'b1;
        step();
        imem_ack = 1'b0;
        n_checks++;
        if (state !== 3'd2 || halted !== 1'b0)
            $display("FAIL halt_decode: got state=%0d halted=%b want state=2 halted=0", state, halted);
        else n_pass++;
        step();
        n_checks++;
        if (state !== 3'd5 || halted !== 1'b1 || imem_req !== 1'b0)
            $display("FAIL halt_enter: got state=%0d halted=%b req=%b want state=5 halted=1 req=0", state, halted, imem_req);
        else n_pass++;
        for (int j = 0; j < 6; j++) begin
            run = 1'($urandom); imem_ack = 1'($urandom); write_enable_in = 1'($urandom);
            branch_select = 1'($urandom); alu_cond = 1'($urandom);
            step();
        end
        n_checks++;
        if (state !== 3'd5 || halted !== 1'b1 || fault !== 1'b0 || pc !== pc_at || retired !== ret_at)
            $display("FAIL halt_frozen: got st=%0d h=%b f=%b pc=%0h ret=%0d want st=5 h=1 f=0 pc=%0h ret=%0d",
                     state, halted, fault, pc, retired, pc_at, ret_at);
        else n_pass++;
    endtask

    task automatic test_timeout();
        do_reset();
        start_run();
        exec_instr(16'h1234, 14, 1'b0, 1'b0, 1'b0, 1'b1);         // ack on the last allowed cycle
        imem_ack = 1'b0;
        for (int j = 0; j < 14; j++) step();
        n_checks++;
        if (state !== 3'd1 || fault !== 1'b0)
            $display("FAIL timeout_early: got state=%0d fault=%b want state=1 fault=0", state, fault);
        else n_pass++;
        step();
        n_checks++;
        if (state !== 3'd6 || fault !== 1'b1 || imem_req !== 1'b0 || halted !== 1'b0)
            $display("FAIL timeout_fault: got state=%0d fault=%b req=%b halted=%b want 6 1 0 0", state, fault, imem_req, halted);
        else n_pass++;
        for (int j = 0; j < 5; j++) begin
            run = 1'($urandom); imem_ack = 1'($urandom); imem_data = 16'($urandom);
            step();
        end
        n_checks++;
        if (state !== 3'd6 || fault !== 1'b1 || pc !== m_pc || retired !== m_ret)
            $display("FAIL fault_sticky: got state=%0d fault=%b pc=%0h ret=%0d want 6 1 %0h %0d",
                     state, fault, pc, retired, m_pc, m_ret);
        else n_pass++;
        do_reset();
        n_checks++;
        if (state !== 3'd0 || fault !== 1'b0)
            $display("FAIL fault_clear: got state=%0d fault=%b want 0 0", state, fault);
        else n_pass++;
    endtask

    task automatic test_reset_priority();
        // Reset during WRITEBACK.
        do_reset();
        start_run();
        exec_instr(16'h0C01, 0, 1'b0, 1'b0, 1'b0, 1'b1);
        imem_data = 16'h5555; imem_ack = 1'b1;
        step(); imem_ack = 1'b0;
        step();
        write_enable_in = 1'b1; run = 1'b1;
        step();
        n_checks++;
        if (state !== 3'd4 || reg_write !== 1'b1)
            $display("FAIL pre_reset_wb: got state=%0d rw=%b want 4 1", state, reg_write);
        else n_pass++;
        reset = 1'b1;
        step();
        reset = 1'b0;
        n_checks++;
        if (state !== 3'd0 || reg_write !== 1'b0 || pc !== 8'd0 || retired !== 16'd0)
            $display("FAIL reset_wb: got state=%0d rw=%b pc=%0h ret=%0d want 0 0 0 0", state, reg_write, pc, retired);
        else n_pass++;
        // Reset with an ack pending in FETCH: the ack is dropped.
        start_run();
        imem_data = 16'hABCD; imem_ack = 1'b1; reset = 1'b1;
        step();
        reset = 1'b0; imem_ack = 1'b0; run = 1'b0;
        n_checks++;
        if (state !== 3'd0 || {command_group, command, operand} !== 16'd0 || imem_req !== 1'b0)
            $display("FAIL reset_fetch: got state=%0d ir=%h req=%b want 0 0000 0",
                     state, {command_group, command, operand}, imem_req);
        else n_pass++;
        m_pc = 8'd0; m_ret = 16'd0;
    endtask

    initial begin
        reset = 1'b1; run = 1'b0; imem_ack = 1'b0; imem_data = 16'd0;
        write_enable_in = 1'b0; branch_select = 1'b0; alu_cond = 1'b0;
        m_pc = 8'd0; m_ret = 16'd0;
        test_reset();
        test_straight_line();
        test_jump();
        test_wrap();
        test_random();
        test_halt();
        test_timeout();
        test_reset_priority();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/cpu_sequencer.md
CPU_SEQUENCER -- requirements
Module: cpu_sequencer

Interface
REQ-001 Parameter PC_WIDTH, default 8: program counter and instruction address width.
REQ-002 Parameter FETCH_TIMEOUT, default 15: maximum FETCH cycles without imem_ack before fault.
REQ-003 Port clk input 1: single clock; all state changes on its rising edge.
REQ-004 Port reset input 1: synchronous, active-high reset.
REQ-005 Port run input 1: 1 = start or continue execution; 0 = stop at the next instruction boundary.
REQ-006 Port imem_req output 1: instruction fetch request.
REQ-007 Port imem_addr output PC_WIDTH: fetch address, always equal to pc.
REQ-008 Port imem_ack input 1: instruction memory has imem_data valid this cycle.
REQ-009 Port imem_data input 16: instruction word.
REQ-010 Port command_group output 3: instruction register bits [15:13], sent to the control unit.
REQ-011 Port command output 3: instruction register bits [12:10], sent to the control unit.
REQ-012 Port operand output 10: instruction register bits [9:0], sent to the datapath.
REQ-013 Port write_enable_in input 1: register-write request decoded by the control unit.
REQ-014 Port branch_select input 1: jump-candidate flag decoded by the control unit.
REQ-015 Port alu_cond input 1: ALU branch condition true.
REQ-016 Port reg_write output 1: one-cycle register-file write strobe.
REQ-017 Port pc output PC_WIDTH: current program counter.
REQ-018 Port state output 3: current FSM state encoding.
REQ-019 Port halted output 1: HALT state reached.
REQ-020 Port fault output 1: fetch timeout occurred; sticky.
REQ-021 Port retired output 16: count of completed instructions.

Function
REQ-022 FSM states and encodings: IDLE=0, FETCH=1, DECODE=2, EXECUTE=3, WRITEBACK=4, HALT=5, FAULT=6; encoding 7 goes to IDLE on the next cycle.
REQ-023 IDLE transitions: run=1 -> FETCH; otherwise hold.
REQ-024 FETCH behaviour: imem_req=1 with imem_addr=pc; on imem_ack=1, capture imem_data into the instruction register and go to DECODE; imem_ack may arrive in the first FETCH cycle.
REQ-025 FETCH timeout: a wait counter clears on FETCH entry and increments each FETCH cycle without imem_ack; on the FETCH_TIMEOUT-th such cycle, go to FAULT.
REQ-026 imem_ack outside FETCH is ignored; imem_req=0 in every state except FETCH.
REQ-027 command_group, command and operand are driven continuously from the instruction register, so they are stable from DECODE through WRITEBACK.
REQ-028 DECODE transitions: instruction register 16'hFFFF -> HALT; otherwise -> EXECUTE.
REQ-029 EXECUTE lasts exactly one cycle; write_enable_in, branch_select and alu_cond are sampled on its closing edge.
REQ-030 PC update at the end of EXECUTE: branch_select=1 and alu_cond=1 -> pc=operand[PC_WIDTH-1:0]; otherwise pc=pc+1, with all-ones wrapping to 0.
REQ-031 EXECUTE transitions: write_enable_in=1 -> WRITEBACK; else run=1 -> FETCH; else -> IDLE.
REQ-032 WRITEBACK: reg_write=1 for exactly this one cycle; then run=1 -> FETCH, else -> IDLE.
REQ-033 retired increments by 1 (wrapping at 16 bits) on leaving EXECUTE without writeback and on leaving WRITEBACK; it never increments twice for one instruction.
REQ-034 Latency with ack in the first FETCH cycle: 3 cycles per non-writing instruction, 4 cycles per writing instruction.
REQ-035 run=0 mid-instruction does not abort: the current instruction completes, then the FSM goes to IDLE with pc pointing at the next instruction.
REQ-036 HALT and FAULT are terminal until reset; halted=1 only in HALT; fault=1 only in FAULT; pc and retired are frozen in both.
REQ-037 Taken jump to its own address re-fetches the same address indefinitely; this is legal.

Reset
REQ-038 reset=1 on a clock edge forces: state=IDLE, pc=0, instruction register=0, wait counter=0, retired=0, imem_req=0, reg_write=0, halted=0, fault=0.
REQ-039 reset has priority over every transition in every state, including mid-FETCH and WRITEBACK; a pending imem_ack is discarded.

Verification
REQ-040 Straight-line run: run=1, ack every FETCH, a non-writing instruction then a writing instruction -> reg_write pulses once, pc 0->1->2, retired=2 after 7 cycles.
REQ-041 Jump: instruction at pc=3 with branch_select=1 and alu_cond=1, operand=0x2A -> pc=0x2A; the same with alu_cond=0 -> pc=4.
REQ-042 Wrap: pc=0xFF executes a non-jump -> next imem_addr=0x00.
REQ-043 Timeout: imem_ack held 0 in FETCH -> FAULT after 15 cycles, fault=1; only reset clears it.
REQ-044 Halt and stop: imem_data=16'hFFFF -> halted=1 after DECODE and pc frozen; separately, run dropped during EXECUTE -> instruction retires, FSM goes to IDLE.
REQ-045 Reset mid-WRITEBACK -> next cycle state=IDLE, reg_write=0, pc=0, retired=0.
